// File: rtl/fpu_float_to_int_seq_if.sv
// Operand/result handshake bundle between the FPU issue and writeback stages
// and the float-to-int converter. Signal names follow the FPU datapath naming.
interface fpu_float_to_int_seq_if #(
  parameter int unsigned STD = 15
) ();
  logic          F2I_input_valid;
  logic          F2I_input_ready;
  logic [STD:0]  F2I_input_float;
  logic [2:0]    F2I_input_rm;
  logic          F2I_input_opcode_signed;
  logic          F2I_input_opcode_unsigned;
  logic [31:0]   F2I_output_int;
  logic          F2I_output_valid;
  logic          F2I_output_ready;
  logic          F2I_output_invalid_flag;
  logic          F2I_output_inexact_flag;

  // Issue/writeback side
  modport master (
    output F2I_input_valid, F2I_input_float, F2I_input_rm,
           F2I_input_opcode_signed, F2I_input_opcode_unsigned, F2I_output_ready,
    input  F2I_input_ready, F2I_output_int, F2I_output_valid,
           F2I_output_invalid_flag, F2I_output_inexact_flag
  );

  // Converter side
  modport slave (
    input  F2I_input_valid, F2I_input_float, F2I_input_rm,
           F2I_input_opcode_signed, F2I_input_opcode_unsigned, F2I_output_ready,
    output F2I_input_ready, F2I_output_int, F2I_output_valid,
           F2I_output_invalid_flag, F2I_output_inexact_flag
  );
endinterface

// File: rtl/fpu_float_to_int_seq.sv
// Multi-cycle IEEE16/bfloat16 to 32-bit integer converter (FCVT.W/WU.H style).
// IDLE -> UNPACK -> ALIGN -> ROUND -> DONE; result and NV/NX held until taken.
// Optional macro F2I_FAST_UNPACK_EN: drops UNPACK, classification is folded
// into ALIGN (latency 2 instead of 3, identical results).
module fpu_float_to_int_seq #(
  parameter int unsigned STD  = 15,
  parameter int unsigned MAN  = 9,
  parameter int unsigned EXP  = 4,
  parameter int unsigned BIAS = 15
) (
  input  logic                  clk,
  input  logic                  rst_l,
  fpu_float_to_int_seq_if.slave f2i
);

  localparam int unsigned SW = MAN + 2;   // significand width incl. hidden bit
  localparam int unsigned EW = EXP + 3;   // signed unbiased exponent width
  localparam int unsigned XW = 32 + SW;   // 32 integer bits + SW fraction bits

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] ALIGN  = 3'd2;
  localparam logic [2:0] ROUND  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

`ifdef F2I_FAST_UNPACK_EN
  localparam logic [2:0] ACCEPT_NXT = ALIGN;
`else
  localparam logic [2:0] ACCEPT_NXT = UNPACK;
`endif

  localparam logic signed [EW-1:0] E_TINY = EW'(-2);
  localparam logic signed [EW-1:0] E_OVF  = EW'(32);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;

  logic [STD:0]         r_float;
  logic [2:0]           r_rm;
  logic                 r_signed;

  logic [31:0]          r_int_mag;
  logic                 r_guard;
  logic                 r_sticky;
  logic                 r_ovf;

  logic [31:0]          r_out_int;
  logic                 r_out_valid;
  logic                 r_out_nv;
  logic                 r_out_nx;

  logic [EXP:0]         w_exp_fld;
  logic [MAN:0]         w_man_fld;
  logic                 w_exp_zero;
  logic                 w_exp_ones;
  logic                 w_man_nz;
  logic                 w_is_nan;
  logic                 w_is_inf;
  logic [SW-1:0]        w_sig;
  logic signed [EW-1:0] w_e;

  logic                 w_u_nan;
  logic                 w_u_inf;
  logic [SW-1:0]        w_u_sig;
  logic signed [EW-1:0] w_u_e;

  logic [5:0]           w_sh;
  logic [XW-1:0]        w_aligned;

  logic                 w_neg;
  logic                 w_inc;
  logic [32:0]          w_mag;
  logic                 w_oor;
  logic                 w_nv;
  logic                 w_nx;
  logic [31:0]          w_res;

  // Operand classification from the captured float
  assign w_exp_fld  = r_float[MAN+1 +: EXP+1];
  assign w_man_fld  = r_float[MAN:0];
  assign w_neg      = r_float[STD];
  assign w_exp_zero = ~|w_exp_fld;
  assign w_exp_ones = &w_exp_fld;
  assign w_man_nz   = |w_man_fld;
  assign w_is_nan   = w_exp_ones & w_man_nz;
  assign w_is_inf   = w_exp_ones & ~w_man_nz;
  assign w_sig      = {~w_exp_zero, w_man_fld};
  assign w_e        = w_exp_zero ? (EW'(1) - EW'(BIAS)) : (EW'(w_exp_fld) - EW'(BIAS));

`ifdef F2I_FAST_UNPACK_EN
  assign w_u_nan = w_is_nan;
  assign w_u_inf = w_is_inf;
  assign w_u_sig = w_sig;
  assign w_u_e   = w_e;
`else
  logic                 r_u_nan;
  logic                 r_u_inf;
  logic [SW-1:0]        r_u_sig;
  logic signed [EW-1:0] r_u_e;

  // Register classification results in UNPACK
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_u_nan <= 1'b0;
      r_u_inf <= 1'b0;
      r_u_sig <= '0;
      r_u_e   <= '0;
    end else if (r_state == UNPACK) begin
      r_u_nan <= w_is_nan;
      r_u_inf <= w_is_inf;
      r_u_sig <= w_sig;
      r_u_e   <= w_e;
    end
  end

  assign w_u_nan = r_u_nan;
  assign w_u_inf = r_u_inf;
  assign w_u_sig = r_u_sig;
  assign w_u_e   = r_u_e;
`endif

  // Significand scaled by 2^(e+1): integer in the top 32 bits, fraction below
  assign w_sh      = 6'(w_u_e + EW'(1));
  assign w_aligned = XW'(w_u_sig) << w_sh;

  // Rounding increment decision
  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      3'b000:  w_inc = r_guard & (r_sticky | r_int_mag[0]);
      3'b010:  w_inc = w_neg & (r_guard | r_sticky);
      3'b011:  w_inc = ~w_neg & (r_guard | r_sticky);
      3'b100:  w_inc = r_guard;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_mag = {1'b0, r_int_mag} + 33'(w_inc);

  // Range check, saturation and flag generation
  always_comb begin
    w_oor = r_ovf;
    w_res = w_mag[31:0];
    if (r_signed) begin
      if (w_neg) w_oor = r_ovf | (w_mag > 33'h0_8000_0000);
      else       w_oor = r_ovf | (w_mag > 33'h0_7FFF_FFFF);
    end else begin
      w_oor = r_ovf | w_mag[32] | (w_neg & (|w_mag));
    end
    w_nv = w_u_nan | w_u_inf | w_oor;
    w_nx = (r_guard | r_sticky) & ~w_nv;
    if (w_u_nan || (!w_neg && w_nv))
      w_res = r_signed ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    else if (w_nv)
      w_res = r_signed ? 32'h8000_0000 : 32'h0000_0000;
    else if (r_signed && w_neg)
      w_res = -w_mag[31:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (f2i.F2I_input_valid) w_state_nxt = ACCEPT_NXT;
      UNPACK:  w_state_nxt = ALIGN;
      ALIGN:   w_state_nxt = ROUND;
      ROUND:   w_state_nxt = DONE;
      DONE:    if (f2i.F2I_output_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture operand, rounding mode and opcode on accept
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_float  <= '0;
      r_rm     <= '0;
      r_signed <= 1'b0;
    end else if (r_state == IDLE && f2i.F2I_input_valid) begin
      r_float  <= f2i.F2I_input_float;
      r_rm     <= f2i.F2I_input_rm;
      r_signed <= f2i.F2I_input_opcode_signed | ~f2i.F2I_input_opcode_unsigned;
    end
  end

  // Alignment: integer part, guard, sticky and overflow
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_int_mag <= '0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (r_state == ALIGN) begin
      if (w_u_e >= E_OVF) begin
        r_int_mag <= '0;
        r_guard   <= 1'b0;
        r_sticky  <= 1'b0;
        r_ovf     <= 1'b1;
      end else if (w_u_e <= E_TINY) begin
        r_int_mag <= '0;
        r_guard   <= 1'b0;
        r_sticky  <= |w_u_sig;
        r_ovf     <= 1'b0;
      end else begin
        r_int_mag <= w_aligned[XW-1:SW];
        r_guard   <= w_aligned[SW-1];
        r_sticky  <= |w_aligned[SW-2:0];
        r_ovf     <= 1'b0;
      end
    end
  end

  // Result and flags written once per operation in ROUND
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_out_int <= '0;
      r_out_nv  <= 1'b0;
      r_out_nx  <= 1'b0;
    end else if (r_state == ROUND) begin
      r_out_int <= w_res;
      r_out_nv  <= w_nv;
      r_out_nx  <= w_nx;
    end
  end

  // Output valid tracks DONE
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_out_valid <= 1'b0;
    else        r_out_valid <= (w_state_nxt == DONE);
  end

  assign f2i.F2I_input_ready         = (r_state == IDLE) & rst_l;
  assign f2i.F2I_output_int          = r_out_int;
  assign f2i.F2I_output_valid        = r_out_valid;
  assign f2i.F2I_output_invalid_flag = r_out_nv;
  assign f2i.F2I_output_inexact_flag = r_out_nx;

endmodule

// File: tb/tb_fpu_float_to_int_seq.sv
// Self-checking bench for fpu_float_to_int_seq (IEEE16 configuration).
// Reference model works on the exact value scaled by 2^24 with plain integers.
module tb_fpu_float_to_int_seq;

`ifdef F2I_FAST_UNPACK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    logic [15:0] f;
    logic [2:0]  rm;
    logic [1:0]  op;   // {signed, unsigned}
    logic [31:0] r;
    logic        nv;
    logic        nx;
  } vec_t;

  logic clk;
  logic rst_l;
  int   n_tests;
  int   n_fail;
  logic [33:0] exp_q[$];
  vec_t vecs[$];

  fpu_float_to_int_seq_if #(.STD(15)) bus ();

  fpu_float_to_int_seq dut (
    .clk   (clk),
    .rst_l (rst_l),
    .f2i   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Returns {nv, nx, int} computed from the real value of the half operand
  function automatic logic [33:0] model(input logic [15:0] f, input logic [2:0] rm, input logic [1:0] op);
    int     ef;
    int     mf;
    bit     neg;
    bit     sgn;
    bit     up;
    bit     oor;
    longint v;
    longint ip;
    longint fr;
    longint sv;
    logic [31:0] sat;
    ef  = int'(f[14:10]);
    mf  = int'(f[9:0]);
    neg = f[15];
    sgn = op[1] || !op[0];
    if (ef == 31) begin
      if (mf != 0) return {2'b10, (sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF)};
      if (neg)     return {2'b10, (sgn ? 32'h8000_0000 : 32'h0000_0000)};
      return {2'b10, (sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF)};
    end
    if (ef == 0) v = longint'(mf);
    else         v = longint'(1024 + mf) << (ef - 1);
    ip = v >>> 24;
    fr = v & 64'hFF_FFFF;
    case (rm)
      3'b000:  up = (fr > 64'h80_0000) || (fr == 64'h80_0000 && ip[0]);
      3'b010:  up = neg && fr != 0;
      3'b011:  up = !neg && fr != 0;
      3'b100:  up = fr >= 64'h80_0000;
      default: up = 1'b0;
    endcase
    if (up) ip = ip + 1;
    sv = neg ? -ip : ip;
    if (sgn) oor = (sv < -64'sd2147483648) || (sv > 64'sd2147483647);
    else     oor = (sv < 0) || (sv > 64'sd4294967295);
    if (oor) begin
      if (neg) sat = sgn ? 32'h8000_0000 : 32'h0000_0000;
      else     sat = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      return {2'b10, sat};
    end
    return {1'b0, (fr != 0), sv[31:0]};
  endfunction

  function automatic vec_t mk(input logic [15:0] f, input logic [2:0] rm, input logic [1:0] op,
                              input logic [31:0] r, input logic nv, input logic nx);
    vec_t v;
    v.f = f; v.rm = rm; v.op = op; v.r = r; v.nv = nv; v.nx = nx;
    return v;
  endfunction

  // Scoreboard: push model result on accept, pop on take, drop all on reset
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      exp_q.delete();
    end else begin
      if (bus.F2I_output_valid && bus.F2I_output_ready && exp_q.size() > 0)
        void'(exp_q.pop_front());
      if (bus.F2I_input_valid && bus.F2I_input_ready)
        exp_q.push_back(model(bus.F2I_input_float, bus.F2I_input_rm,
                              {bus.F2I_input_opcode_signed, bus.F2I_input_opcode_unsigned}));
    end
  end

  // Compare held outputs against the model every cycle they are valid
  always @(negedge clk) begin
    if (rst_l && bus.F2I_output_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL monitor: output_valid with no expected result");
      end else begin
        check("monitor", {bus.F2I_output_invalid_flag, bus.F2I_output_inexact_flag, bus.F2I_output_int},
              exp_q[0]);
      end
    end
  end

  // Present one operand, wait for accept, then for output_valid; checks latency
  task automatic issue(input logic [15:0] f, input logic [2:0] rm, input logic [1:0] op);
    int w;
    int lat;
    @(negedge clk);
    bus.F2I_input_float           = f;
    bus.F2I_input_rm              = rm;
    bus.F2I_input_opcode_signed   = op[1];
    bus.F2I_input_opcode_unsigned = op[0];
    bus.F2I_input_valid           = 1'b1;
    w = 0;
    while (!bus.F2I_input_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: input_ready stayed 0");
    end
    @(posedge clk);
    #1;
    bus.F2I_input_valid = 1'b0;
    lat = 0;
    while (!bus.F2I_output_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
  endtask

  task automatic take();
    bus.F2I_output_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.F2I_output_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    issue(v.f, v.rm, v.op);
    check($sformatf("vec%0d_dut", idx),
          {bus.F2I_output_invalid_flag, bus.F2I_output_inexact_flag, bus.F2I_output_int},
          {v.nv, v.nx, v.r});
    check($sformatf("vec%0d_model", idx), model(v.f, v.rm, v.op), {v.nv, v.nx, v.r});
    take();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_l   = 1'b0;
    bus.F2I_input_valid           = 1'b0;
    bus.F2I_input_float           = '0;
    bus.F2I_input_rm              = '0;
    bus.F2I_input_opcode_signed   = 1'b0;
    bus.F2I_input_opcode_unsigned = 1'b0;
    bus.F2I_output_ready          = 1'b0;

    vecs.push_back(mk(16'h3E00, 3'b000, 2'b10, 32'h0000_0002, 1'b0, 1'b1));
    vecs.push_back(mk(16'h4100, 3'b000, 2'b10, 32'h0000_0002, 1'b0, 1'b1));
    vecs.push_back(mk(16'h4100, 3'b100, 2'b10, 32'h0000_0003, 1'b0, 1'b1));
    vecs.push_back(mk(16'h4100, 3'b011, 2'b10, 32'h0000_0003, 1'b0, 1'b1));
    vecs.push_back(mk(16'hC100, 3'b010, 2'b10, 32'hFFFF_FFFD, 1'b0, 1'b1));
    vecs.push_back(mk(16'hC100, 3'b001, 2'b10, 32'hFFFF_FFFE, 1'b0, 1'b1));
    vecs.push_back(mk(16'h7BFF, 3'b001, 2'b01, 32'h0000_FFE0, 1'b0, 1'b0));
    vecs.push_back(mk(16'h8000, 3'b000, 2'b10, 32'h0000_0000, 1'b0, 1'b0));
    vecs.push_back(mk(16'h7C00, 3'b000, 2'b10, 32'h7FFF_FFFF, 1'b1, 1'b0));
    vecs.push_back(mk(16'h7E00, 3'b000, 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b0));
    vecs.push_back(mk(16'hBC00, 3'b000, 2'b01, 32'h0000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(16'hB400, 3'b000, 2'b01, 32'h0000_0000, 1'b0, 1'b1));
    vecs.push_back(mk(16'hFC00, 3'b001, 2'b10, 32'h8000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(16'h0001, 3'b011, 2'b10, 32'h0000_0001, 1'b0, 1'b1));
    vecs.push_back(mk(16'h3E00, 3'b111, 2'b10, 32'h0000_0001, 1'b0, 1'b1));
    vecs.push_back(mk(16'h3800, 3'b000, 2'b10, 32'h0000_0000, 1'b0, 1'b1));
    vecs.push_back(mk(16'h3800, 3'b100, 2'b10, 32'h0000_0001, 1'b0, 1'b1));
    vecs.push_back(mk(16'hBC00, 3'b000, 2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0));
    vecs.push_back(mk(16'hBC00, 3'b000, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0));
    vecs.push_back(mk(16'hC100, 3'b000, 2'b01, 32'h0000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(16'h7BFF, 3'b000, 2'b10, 32'h0000_FFE0, 1'b0, 1'b0));
    vecs.push_back(mk(16'hB400, 3'b010, 2'b01, 32'h0000_0000, 1'b1, 1'b0));

    // Reset values while rst_l is low
    #23;
    check("rst_valid", 64'(bus.F2I_output_valid), 64'(0));
    check("rst_int",   64'(bus.F2I_output_int), 64'(0));
    check("rst_flags", 64'({bus.F2I_output_invalid_flag, bus.F2I_output_inexact_flag}), 64'(0));
    check("rst_ready", 64'(bus.F2I_input_ready), 64'(0));
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    check("ready_after_rst", 64'(bus.F2I_input_ready), 64'(1));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure: 2.5 RMM signed -> 3, NX; hold output_ready low 5 cycles
    issue(16'h4100, 3'b100, 2'b10);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 64'(bus.F2I_output_valid), 64'(1));
      check("bp_in_ready", 64'(bus.F2I_input_ready), 64'(0));
      check("bp_result", {bus.F2I_output_invalid_flag, bus.F2I_output_inexact_flag, bus.F2I_output_int},
            {2'b01, 32'h0000_0003});
    end
    take();
    check("bp_idle_valid", 64'(bus.F2I_output_valid), 64'(0));
    check("bp_idle_ready", 64'(bus.F2I_input_ready), 64'(1));

    // Reset pulse while the operation is in ALIGN
    @(negedge clk);
    bus.F2I_input_float           = 16'h4100;
    bus.F2I_input_rm              = 3'b100;
    bus.F2I_input_opcode_signed   = 1'b1;
    bus.F2I_input_opcode_unsigned = 1'b0;
    bus.F2I_input_valid           = 1'b1;
    @(posedge clk);
    #1;
    bus.F2I_input_valid = 1'b0;
`ifndef F2I_FAST_UNPACK_EN
    @(posedge clk);
    #1;
`endif
    rst_l = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.F2I_output_valid), 64'(0));
    check("midrst_int",   64'(bus.F2I_output_int), 64'(0));
    check("midrst_flags", 64'({bus.F2I_output_invalid_flag, bus.F2I_output_inexact_flag}), 64'(0));
    check("midrst_ready", 64'(bus.F2I_input_ready), 64'(0));
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    check("midrst_release_ready", 64'(bus.F2I_input_ready), 64'(1));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("midrst_dropped", 64'(bus.F2I_output_valid), 64'(0));
    end

    // Recovery after reset: 1.0 signed RNE -> 1, no flags
    run_vec(mk(16'h3C00, 3'b000, 2'b10, 32'h0000_0001, 1'b0, 1'b0), 99);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_float_to_int_seq.md
# fpu_float_to_int_seq

Multi-cycle floating-point-to-integer converter (FCVT.W/WU.H style): the reverse direction of the FPU's integer-to-float path. It accepts one IEEE16/bfloat16 operand over a valid/ready handshake, then unpacks, aligns and rounds it to a signed or unsigned 32-bit integer in a fixed-latency state machine. The result and IEEE flags are held until the FPU writeback stage takes them.

## Interface
- std, 15: float MSB index (width std+1)
- man, 9: mantissa MSB index (stored mantissa man+1 bits); 6 for bfloat16
- exp, 4: exponent MSB index; 7 for bfloat16
- bias, 15: exponent bias; 127 for bfloat16
- clk  in  1  clock; all state updates on rising edge
- rst_l  in  1  reset; one clock, asynchronous, active-low
- F2I_input_valid  in  1  operand valid
- F2I_input_ready  out  1  high only in IDLE with rst_l high
- F2I_input_float  in  std+1  operand {sign, exponent, mantissa}
- F2I_input_rm  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes behave as RTZ
- F2I_input_opcode_signed  in  1  signed result; wins if both opcodes high or neither
- F2I_input_opcode_unsigned  in  1  unsigned result
- F2I_output_int  out  32  result
- F2I_output_valid  out  1  result valid (DONE state)
- F2I_output_ready  in  1  consumer accepts result
- F2I_output_invalid_flag  out  1  NV
- F2I_output_inexact_flag  out  1  NX

## Operation
- States: IDLE, UNPACK, ALIGN, ROUND, DONE.
- IDLE: input_ready=1. On valid&ready, capture float, rm and opcode into registers, go to UNPACK.
- UNPACK: classify NaN (exp all-ones, mant≠0), Inf (exp all-ones, mant=0), zero, subnormal (hidden bit 0, effective exponent 1-bias). Compute unbiased exponent e as a signed exp+3-bit value. Go to ALIGN.
- ALIGN: significand {hidden, mant} placed in a 32-bit integer field plus fraction.
  - Integer = significand shifted left by e-(man+1), or right by (man+1)-e.
  - guard = first fraction bit; sticky = OR of the remaining fraction bits.
  - e ≥ 32: overflow flag set; no shift performed.
  - e = -1: guard = hidden bit.
  - e ≤ -2: integer = 0, guard = 0, sticky = |significand.
  - Go to ROUND.
- ROUND: increment the magnitude when any of the following holds:
  - RNE: g&(s|lsb)
  - RMM: g
  - RUP: positive & (g|s)
  - RDN: negative & (g|s)
- ROUND, range check: 33-bit magnitude after increment.
  - Signed limits: positive ≤ 2^31-1, negative ≤ 2^31.
  - Unsigned limit: ≤ 2^32-1.
  - Negative input with nonzero rounded magnitude is out of range for unsigned.
  - If in range, negate (two's complement) when signed and negative.
- ROUND, saturation when invalid:
  - NaN or +Inf/positive overflow → 0x7FFFFFFF (signed) or 0xFFFFFFFF (unsigned).
  - -Inf/negative overflow → 0x80000000 (signed) or 0x00000000 (unsigned).
- ROUND, flags:
  - invalid = NaN | Inf | out-of-range.
  - inexact = (g|s) & ~invalid.
  - -0.0 → 0x00000000 with no flags.
  - Register result and flags; go to DONE.
- DONE: output_valid=1. On output_ready go to IDLE. output_int and flags retain their values until the next ROUND write.

## Timing
- Accept edge E0 enters UNPACK; E1 enters ALIGN; E2 enters ROUND; E3 enters DONE. output_valid rises 3 cycles after accept.
- Minimum spacing between accepts is 4 cycles plus the DONE cycle. No accept occurs in the cycle that output is taken.
- Backpressure: output_valid, output_int and flags are stable while output_ready is low.
- Reset values: output_valid=0, output_int=0, both flags 0, state IDLE, input_ready=0 while rst_l low.
- Reset asserted mid-operation aborts the operation immediately: in-flight data is dropped, outputs return to reset values, and input_ready=1 on the first cycle after release.

## Configuration
- Macro: F2I_FAST_UNPACK_EN.
- Defined: the UNPACK state is removed; classification and exponent computation are folded into ALIGN. Accept edge enters ALIGN, latency is 2 cycles, and results are identical.
- Undefined: five-state machine, latency 3 cycles.

## Test plan
- 0x3E00 (1.5) signed RNE → 0x00000002, NX=1; 0x4100 (2.5) RNE → 0x00000002, RMM → 0x00000003, RUP → 0x00000003, NX=1.
- 0xC100 (-2.5) signed RDN → 0xFFFFFFFD; RTZ → 0xFFFFFFFE; NX=1, NV=0.
- 0x7BFF (65504) unsigned RTZ → 0x0000FFE0, no flags; 0x8000 (-0.0) signed → 0, no flags.
- 0x7C00 signed → 0x7FFFFFFF NV=1; 0x7E00 unsigned → 0xFFFFFFFF NV=1; 0xBC00 (-1.0) unsigned → 0 NV=1, NX=0; 0xB400 (-0.25) unsigned RNE → 0, NX=1, NV=0.
- output_ready held low 5 cycles → output_valid/int/flags constant, input_ready=0; then output_ready=1 → IDLE next cycle. rst_l pulsed low in ALIGN → output_valid=0, output_int=0, input_ready=1 after release.
- Latency: output_valid rises exactly 3 cycles after accept; exactly 2 cycles with F2I_FAST_UNPACK_EN defined.
